sort_controller: RTL and testbench
==================================

Name: sort_controller

Overview:
Sequencing controller for the 8x8 synchronous-read register memory (separate read/write ports, 1-cycle read latency). It owns the memory's control and address lines and shares them between two users. When idle, an external host loads and reads entries. After `start`, an internal selection-sort engine rearranges the contents into ascending unsigned order in place and then hands the memory back to the host.

Parameters:
AW, 3, address width; memory depth DEPTH = 2**AW
DW, 8, data width

Ports:
clk  input  1  single clock; all state updates on posedge
rst  input  1  reset, synchronous, active-high
start  input  1  begin sort; sampled only when ready=1
wr  input  1  host write strobe; honoured only when ready=1 and start=0
addr  input  AW  host read/write address
datain  input  DW  host write data
dataout  output  DW  host read data
ready  output  1  1 = idle, host owns memory; 0 = sort in progress
done  output  1  1-cycle pulse when a sort completes
mem_rd  output  1  memory read enable
mem_wr  output  1  memory write enable
mem_rdaddr  output  AW  memory read address
mem_wraddr  output  AW  memory write address
mem_wdata  output  DW  memory write data
mem_rdata  input  DW  memory read data; valid the cycle after mem_rd

Behaviour:
- Reset, sampled at posedge with rst=1:
  - state=IDLE, ready=1, done=0, i=j=minidx=0, min=0.
  - While rst=1, mem_rd=mem_wr=0, addresses=0, mem_wdata=0, dataout=0.
- Memory control outputs are combinational from state and registers. Unlisted controls are 0.
- Reset mid-sort returns to IDLE immediately. Memory contents are left partially sorted, with no restore.
- IDLE (ready=1):
  - mem_rd=1, mem_rdaddr=addr.
  - dataout=mem_rdata, i.e. mem[addr of the previous cycle].
  - If wr=1 and start=0: mem_wr=1, mem_wraddr=addr, mem_wdata=datain.
  - If start=1: wr is ignored (start has priority); i<=0; go OUTER. ready=0 from the next cycle.
- Busy (ready=0): start and wr are ignored; dataout=0.
- OUTER:
  - If i==DEPTH-1: go IDLE, ready<=1, done<=1 for one cycle.
  - Else: mem_rd=1, rdaddr=i; minidx<=i; j<=i+1; go FIRST.
- FIRST: min<=mem_rdata (=mem[i]); mem_rd=1, rdaddr=j; go SCAN.
- SCAN, where mem_rdata=mem[j]:
  - If mem_rdata < min (strict, unsigned): min<=mem_rdata, minidx<=j. Ties keep the earlier index.
  - If j==DEPTH-1: go SWAP1.
  - Else: mem_rd=1, rdaddr=j+1; j<=j+1.
- SWAP1:
  - If minidx==i: i<=i+1; go OUTER, with no writes.
  - Else: mem_rd=1, rdaddr=i; go SWAP2.
- SWAP2: mem_wr=1, wraddr=minidx, wdata=mem_rdata (old mem[i]); go SWAP3.
- SWAP3: mem_wr=1, wraddr=i, wdata=min; i<=i+1; go OUTER.
- Latency: per i in 0..DEPTH-2 the cost is 3+(DEPTH-1-i) cycles, +2 if a swap occurs, plus 1 final OUTER cycle.
  - DEPTH=8 with no swaps: 50 busy cycles.
  - Each swap adds 2 cycles.
- done is asserted in the same cycle that ready returns to 1.
- Counters i and j never wrap: j stops at DEPTH-1 and i terminates at DEPTH-1.
- Never mem_rd and mem_wr to the same address in one busy cycle.

Test Plan:
- Reset → ready=1, done=0, mem_wr=0; assert rst for 1 cycle mid-sort → IDLE next cycle, ready=1, no done pulse.
- Host load/readback: write 8'h11..8'h88 to addrs 0..7; then set addr=k → dataout=mem[k] one cycle later; pulse wr together with start → write ignored, sort starts.
- Already sorted 1,2,...,8, pulse start → ready low for exactly 50 cycles, no mem_wr ever, done pulse with ready rise, contents unchanged.
- Reversed 8,7,...,1 → 4 swaps (0↔7, 1↔6, 2↔5, 3↔4), 58 busy cycles, final contents 1..8.
- All entries equal 8'h5A → 50 cycles, no writes; duplicates mix {3,1,3,0,255,1,0,7} → {0,0,1,1,3,3,7,255}.
- start/wr toggled during busy → ignored: memory only changed by sort writes, and after done a new start begins a fresh sort.

Source files
------------

// File: rtl/sort_controller_if.sv
// rtl/sort_controller_if.sv - memory-side bus between the sort controller and the 8x8 register memory
interface sort_controller_if #(
  parameter int AW = 3,
  parameter int DW = 8
);
  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] mem_rdaddr;
  logic [AW-1:0] mem_wraddr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Controller side: owns all control, address and write-data lines.
  modport master (
    output mem_rd, mem_wr, mem_rdaddr, mem_wraddr, mem_wdata,
    input  mem_rdata
  );

  // Memory side: returns read data one cycle after mem_rd.
  modport slave (
    input  mem_rd, mem_wr, mem_rdaddr, mem_wraddr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/sort_controller.sv
// rtl/sort_controller.sv - host access / in-place selection sort sequencer for a sync-read register memory
module sort_controller #(
  parameter int AW = 3,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          wr,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] datain,
  output logic [DW-1:0] dataout,
  output logic          ready,
  output logic          done,
  sort_controller_if.master mem
);

  localparam logic [AW-1:0] LAST = AW'((2 ** AW) - 1);

  typedef enum logic [2:0] {
    IDLE,
    OUTER,
    FIRST,
    SCAN,
    SWAP1,
    SWAP2,
    SWAP3
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] i, i_n;
  logic [AW-1:0] j, j_n;
  logic [AW-1:0] minidx, minidx_n;
  logic [DW-1:0] min_val, min_n;
  logic          done_n;

  logic          rd_c;
  logic          wr_c;
  logic [AW-1:0] rdaddr_c;
  logic [AW-1:0] wraddr_c;
  logic [DW-1:0] wdata_c;
  logic [DW-1:0] dout_c;

  // State and sort bookkeeping registers; reset abandons any sort in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      i       <= '0;
      j       <= '0;
      minidx  <= '0;
      min_val <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      i       <= i_n;
      j       <= j_n;
      minidx  <= minidx_n;
      min_val <= min_n;
      done    <= done_n;
    end
  end

  // Next-state and memory control: host owns the memory in IDLE, the sort engine otherwise.
  always_comb begin
    state_n  = state;
    i_n      = i;
    j_n      = j;
    minidx_n = minidx;
    min_n    = min_val;
    done_n   = 1'b0;
    rd_c     = 1'b0;
    wr_c     = 1'b0;
    rdaddr_c = '0;
    wraddr_c = '0;
    wdata_c  = '0;
    dout_c   = '0;
    case (state)
      IDLE: begin
        rd_c     = 1'b1;
        rdaddr_c = addr;
        dout_c   = mem.mem_rdata;
        if (start) begin
          // start wins over a simultaneous host write
          i_n     = '0;
          state_n = OUTER;
        end else if (wr) begin
          wr_c     = 1'b1;
          wraddr_c = addr;
          wdata_c  = datain;
        end
      end
      OUTER: begin
        if (i == LAST) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          rd_c     = 1'b1;
          rdaddr_c = i;
          minidx_n = i;
          j_n      = i + AW'(1);
          state_n  = FIRST;
        end
      end
      FIRST: begin
        min_n    = mem.mem_rdata;
        rd_c     = 1'b1;
        rdaddr_c = j;
        state_n  = SCAN;
      end
      SCAN: begin
        // strict compare keeps the earliest index among equal minima
        if (mem.mem_rdata < min_val) begin
          min_n    = mem.mem_rdata;
          minidx_n = j;
        end
        if (j == LAST) begin
          state_n = SWAP1;
        end else begin
          rd_c     = 1'b1;
          rdaddr_c = j + AW'(1);
          j_n      = j + AW'(1);
        end
      end
      SWAP1: begin
        if (minidx == i) begin
          i_n     = i + AW'(1);
          state_n = OUTER;
        end else begin
          rd_c     = 1'b1;
          rdaddr_c = i;
          state_n  = SWAP2;
        end
      end
      SWAP2: begin
        // old mem[i] moves to the slot the minimum came from
        wr_c     = 1'b1;
        wraddr_c = minidx;
        wdata_c  = mem.mem_rdata;
        state_n  = SWAP3;
      end
      SWAP3: begin
        wr_c     = 1'b1;
        wraddr_c = i;
        wdata_c  = min_val;
        i_n      = i + AW'(1);
        state_n  = OUTER;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // All memory-facing and host read outputs are forced quiet while reset is held.
  assign mem.mem_rd     = rd_c & ~rst;
  assign mem.mem_wr     = wr_c & ~rst;
  assign mem.mem_rdaddr = rst ? '0 : rdaddr_c;
  assign mem.mem_wraddr = rst ? '0 : wraddr_c;
  assign mem.mem_wdata  = rst ? '0 : wdata_c;
  assign dataout        = rst ? '0 : dout_c;
  assign ready          = (state == IDLE);

endmodule

// File: tb/tb_sort_controller.sv
// tb/tb_sort_controller.sv - self-checking bench for sort_controller with a sync-read memory model
module tb_sort_controller;

  localparam int AW = 3;
  localparam int DW = 8;
  localparam int DEPTH = 8;

  logic          clk;
  logic          rst;
  logic          start;
  logic          wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] datain;
  logic [DW-1:0] dataout;
  logic          ready;
  logic          done;

  sort_controller_if #(.AW(AW), .DW(DW)) mem_if ();

  sort_controller #(.AW(AW), .DW(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .wr      (wr),
    .addr    (addr),
    .datain  (datain),
    .dataout (dataout),
    .ready   (ready),
    .done    (done),
    .mem     (mem_if.master)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] cur [DEPTH];
  logic [DW-1:0] expm [DEPTH];
  logic [15:0]   wq [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 8x8 register memory, one-cycle read latency
  always @(posedge clk) begin
    if (mem_if.mem_wr) ram[mem_if.mem_wraddr] <= mem_if.mem_wdata;
    if (mem_if.mem_rd) mem_if.mem_rdata <= ram[mem_if.mem_rdaddr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Busy-cycle write monitor: each sort write must be the next one the model predicts.
  always @(negedge clk) begin
    if (!rst && ready === 1'b0 && mem_if.mem_wr === 1'b1) begin
      if (wq.size() == 0) begin
        chk("unexpected_busy_write", {8'(mem_if.mem_wraddr), mem_if.mem_wdata}, 32'hFFFF_FFFF);
      end else begin
        chk("busy_write", {8'(mem_if.mem_wraddr), mem_if.mem_wdata}, wq.pop_front());
      end
      if (mem_if.mem_rd === 1'b1)
        chk("rd_wr_same_addr", 32'(mem_if.mem_rdaddr == mem_if.mem_wraddr), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input int k, input logic [DW-1:0] d);
    addr   = AW'(k);
    datain = d;
    wr     = 1'b1;
    tick();
    wr     = 1'b0;
  endtask

  // Selection sort on plain arrays; also queues the expected write sequence.
  task automatic model_sort(output int swaps);
    int m;
    logic [DW-1:0] t;
    swaps = 0;
    for (int k = 0; k < DEPTH; k++) expm[k] = cur[k];
    for (int a = 0; a < DEPTH - 1; a++) begin
      m = a;
      for (int b = a + 1; b < DEPTH; b++)
        if (expm[b] < expm[m]) m = b;
      if (m != a) begin
        wq.push_back({8'(m), expm[a]});
        wq.push_back({8'(a), expm[m]});
        t = expm[a];
        expm[a] = expm[m];
        expm[m] = t;
        swaps++;
      end
    end
  endtask

  task automatic run_sort(input string name, input bit with_wr, input bit noise);
    int swaps;
    int cnt;
    for (int k = 0; k < DEPTH; k++) host_write(k, cur[k]);
    model_sort(swaps);
    start  = 1'b1;
    wr     = with_wr;
    addr   = 3'd3;
    datain = 8'hEE;
    tick();
    start  = 1'b0;
    wr     = 1'b0;
    chk({name, "_ready_low"}, 32'(ready), 32'd0);
    chk({name, "_busy_dout"}, 32'(dataout), 32'd0);
    cnt = 0;
    while (ready === 1'b0 && cnt < 300) begin
      cnt++;
      if (noise) begin
        start  = 1'($urandom);
        wr     = 1'($urandom);
        addr   = AW'($urandom);
        datain = DW'($urandom);
      end
      tick();
    end
    start = 1'b0;
    wr    = 1'b0;
    chk({name, "_busy_cycles"}, 32'(cnt), 32'(50 + 2 * swaps));
    chk({name, "_done_with_ready"}, 32'(done), 32'd1);
    chk({name, "_writes_left"}, 32'(wq.size()), 32'd0);
    wq.delete();
    tick();
    chk({name, "_done_pulse_end"}, 32'(done), 32'd0);
    for (int k = 0; k < DEPTH; k++) begin
      addr = AW'(k);
      tick();
      chk($sformatf("%s_result[%0d]", name, k), 32'(dataout), 32'(expm[k]));
    end
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    wr     = 1'b0;
    addr   = '0;
    datain = '0;
    tick();
    tick();
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mem_wr", 32'(mem_if.mem_wr), 32'd0);
    chk("rst_mem_rd", 32'(mem_if.mem_rd), 32'd0);
    chk("rst_dataout", 32'(dataout), 32'd0);
    rst = 1'b0;
    tick();

    for (int k = 0; k < DEPTH; k++) host_write(k, 8'((k + 1) * 8'h11));
    for (int k = DEPTH - 1; k >= 0; k--) begin
      addr = AW'(k);
      tick();
      chk($sformatf("readback[%0d]", k), 32'(dataout), 32'((k + 1) * 8'h11));
    end

    for (int k = 0; k < DEPTH; k++) cur[k] = 8'((k + 1) * 8'h11);
    run_sort("start_with_wr", 1'b1, 1'b0);

    for (int k = 0; k < DEPTH; k++) cur[k] = 8'(k + 1);
    run_sort("sorted", 1'b0, 1'b0);

    for (int k = 0; k < DEPTH; k++) cur[k] = 8'(DEPTH - k);
    run_sort("reversed", 1'b0, 1'b0);

    for (int k = 0; k < DEPTH; k++) cur[k] = 8'h5A;
    run_sort("all_equal", 1'b0, 1'b0);

    cur = '{8'd3, 8'd1, 8'd3, 8'd0, 8'd255, 8'd1, 8'd0, 8'd7};
    run_sort("dups", 1'b0, 1'b0);

    for (int k = 0; k < DEPTH; k++) cur[k] = DW'($urandom);
    run_sort("noise", 1'b0, 1'b1);
    for (int k = 0; k < DEPTH; k++) cur[k] = DW'($urandom_range(0, 3));
    run_sort("fresh_after_noise", 1'b0, 1'b0);

    for (int k = 0; k < DEPTH; k++) host_write(k, 8'(DEPTH - k));
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 5; n++) tick();
    chk("midsort_busy", 32'(ready), 32'd0);
    rst = 1'b1;
    tick();
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_mem_rd", 32'(mem_if.mem_rd), 32'd0);
    chk("midrst_dataout", 32'(dataout), 32'd0);
    rst = 1'b0;
    wq.delete();
    tick();
    chk("after_rst_ready", 32'(ready), 32'd1);
    chk("after_rst_done", 32'(done), 32'd0);

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < DEPTH; k++) cur[k] = DW'($urandom_range(0, 15));
      run_sort($sformatf("rand%0d", r), 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
